// File: rtl/norm_shift.sv
// norm_shift: normalizing left shifter for the sfpu datapath.
// Moves the highest set bit of the mantissa to bit XLEN-1 and lowers the
// exponent by the same amount. The exponent stops at 0, and a result that
// stops there is flagged subnormal. Valid/ready handshake with full
// backpressure.
// Build option: define NORM_SHIFT_PIPE2_EN to add the stage A/B register.
// That build has a latency of 2. Without it, stage A feeds stage B
// combinationally and the latency is 1.
module norm_shift #(
    parameter int XLEN = 128,
    parameter int XLOG = 7,
    parameter int ELEN = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_mant,
    input  logic [XLOG-1:0] in_pos,
    input  logic            in_nz,
    input  logic [ELEN-1:0] in_exp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_mant,
    output logic [ELEN-1:0] out_exp,
    output logic            out_zero,
    output logic            out_sub
);

    // Comparison width for shift amount versus exponent.
    localparam int CW   = (XLOG > ELEN) ? XLOG : ELEN;
    // Stage B shifts by the low LO_W bits; stage A shifts by the rest.
    localparam int LO_W = XLOG / 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_t;

    // Clamp when the exponent cannot absorb the full leading-zero count.
    function automatic logic clamp_needed(input logic [XLOG-1:0] shamt,
                                          input logic [ELEN-1:0] exp);
        return CW'(shamt) >= CW'(exp);
    endfunction

    // Actual shift: the leading-zero count, limited by the exponent.
    function automatic logic [XLOG-1:0] applied_shift(input logic [XLOG-1:0] shamt,
                                                      input logic [ELEN-1:0] exp,
                                                      input logic            clamp);
        return clamp ? XLOG'(exp) : shamt;
    endfunction

    // Exponent after normalization. It is forced to 0 when clamped or when
    // the mantissa is zero.
    function automatic logic [ELEN-1:0] adjust_exp(input logic [ELEN-1:0] exp,
                                                   input logic [XLOG-1:0] sh,
                                                   input logic            nz,
                                                   input logic            clamp);
        logic [CW-1:0] diff;
        diff = CW'(exp) - CW'(sh);
        return (nz && !clamp) ? diff[ELEN-1:0] : '0;
    endfunction

    // ---- stage A: shift decision and coarse shift ----
    logic [XLOG-1:0] shamt_p0;
    logic            clamp_p0;
    logic [XLOG-1:0] sh_p0;
    logic [XLOG-1:0] sh_hi_p0;
    logic [XLEN-1:0] mant_p0;

    assign shamt_p0 = ~in_pos;
    assign clamp_p0 = clamp_needed(shamt_p0, in_exp);
    assign sh_p0    = applied_shift(shamt_p0, in_exp, clamp_p0);
    assign sh_hi_p0 = {sh_p0[XLOG-1:LO_W], {LO_W{1'b0}}};
    assign mant_p0  = in_nz ? (in_mant << sh_hi_p0) : '0;

    // Signals that feed stage B: registers in the 2-stage build, wires otherwise.
    logic            vld_p1;
    logic [XLEN-1:0] mant_p1;
    logic [XLOG-1:0] sh_p1;
    logic [ELEN-1:0] exp_p1;
    logic            nz_p1;
    logic            clamp_p1;

    // Output stage control.
    stage_t state_b;
    stage_t state_b_next;
    logic   b_open;

    // Stage B can take a beat when it is empty or is draining this cycle.
    assign b_open = (state_b == EMPTY) || out_ready;

`ifdef NORM_SHIFT_PIPE2_EN
    // ---- stage A/B register ----
    stage_t state_a;
    stage_t state_a_next;
    logic   a_load;

    // in_ready depends on out_ready only, never on in_valid.
    assign in_ready = (state_a == EMPTY) || b_open;
    assign a_load   = in_valid && in_ready;
    assign vld_p1   = (state_a == FULL);

    // Stage A occupancy register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_a <= EMPTY;
        end else begin
            state_a <= state_a_next;
        end
    end

    // Stage A next state: reload or empty whenever the slot is free to change.
    always_comb begin
        state_a_next = state_a;
        if (in_ready) begin
            state_a_next = in_valid ? FULL : EMPTY;
        end
    end

    // Stage A datapath capture on load only.
    always_ff @(posedge clock) begin
        if (a_load) begin
            mant_p1  <= mant_p0;
            sh_p1    <= sh_p0;
            exp_p1   <= in_exp;
            nz_p1    <= in_nz;
            clamp_p1 <= clamp_p0;
        end
    end
`else
    // Stage A flows straight into stage B.
    assign in_ready = b_open;
    assign vld_p1   = in_valid;
    assign mant_p1  = mant_p0;
    assign sh_p1    = sh_p0;
    assign exp_p1   = in_exp;
    assign nz_p1    = in_nz;
    assign clamp_p1 = clamp_p0;
`endif

    // ---- stage B: fine shift, exponent and flags ----
    logic [XLEN-1:0] mant_b;
    logic [ELEN-1:0] exp_b;
    logic            zero_b;
    logic            sub_b;
    logic            b_load;

    assign mant_b = mant_p1 << sh_p1[LO_W-1:0];
    assign exp_b  = adjust_exp(exp_p1, sh_p1, nz_p1, clamp_p1);
    assign zero_b = !nz_p1;
    assign sub_b  = nz_p1 && clamp_p1;
    assign b_load = vld_p1 && b_open;

    logic [XLEN-1:0] mant_p2;
    logic [ELEN-1:0] exp_p2;
    logic            zero_p2;
    logic            sub_p2;

    // Output stage occupancy register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_b <= EMPTY;
        end else begin
            state_b <= state_b_next;
        end
    end

    // Output stage next state: take the upstream beat or go empty after a drain.
    always_comb begin
        state_b_next = state_b;
        if (b_open) begin
            state_b_next = vld_p1 ? FULL : EMPTY;
        end
    end

    // Output datapath capture on load only; it holds during a stall.
    always_ff @(posedge clock) begin
        if (b_load) begin
            mant_p2 <= mant_b;
            exp_p2  <= exp_b;
            zero_p2 <= zero_b;
            sub_p2  <= sub_b;
        end
    end

    // ---- outputs ----
    // Gating by valid makes the outputs read as 0 after reset, while the data
    // registers themselves stay unreset.
    assign out_valid = (state_b == FULL);
    assign out_mant  = out_valid ? mant_p2 : '0;
    assign out_exp   = out_valid ? exp_p2  : '0;
    assign out_zero  = out_valid && zero_p2;
    assign out_sub   = out_valid && sub_p2;

endmodule

// File: tb/tb_norm_shift.sv
// tb_norm_shift: directed and randomized bench for norm_shift (XLEN=128, ELEN=12).
// Works with NORM_SHIFT_PIPE2_EN either defined or undefined.
module tb_norm_shift;

    localparam int XLEN = 128;
    localparam int XLOG = 7;
    localparam int ELEN = 12;
`ifdef NORM_SHIFT_PIPE2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [XLEN-1:0] ONE = 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_mant = '0;
    logic [XLOG-1:0] in_pos = '0;
    logic            in_nz = 1'b0;
    logic [ELEN-1:0] in_exp = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_mant;
    logic [ELEN-1:0] out_exp;
    logic            out_zero;
    logic            out_sub;

    norm_shift #(.XLEN(XLEN), .XLOG(XLOG), .ELEN(ELEN)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_pos(in_pos), .in_nz(in_nz), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero), .out_sub(out_sub)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [XLEN-1:0] mant;
        logic [ELEN-1:0] exp;
        logic            zero;
        logic            sub;
    } res_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   acc;

    // Reference model: integer arithmetic on the leading-zero count.
    function automatic res_t model(input logic [XLEN-1:0] m, input logic [XLOG-1:0] pos,
                                   input logic nz, input logic [ELEN-1:0] e);
        res_t r;
        int   lz;
        int   ev;
        r = '0;
        if (!nz) begin
            r.zero = 1'b1;
            return r;
        end
        lz = (XLEN - 1) - int'(pos);
        ev = int'(e);
        if (lz < ev) begin
            r.mant = m << lz;
            r.exp  = ELEN'(ev - lz);
        end else begin
            r.mant = m << ev;
            r.sub  = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: record the accept and check the drain at negedge, then step past posedge.
    task automatic cycle();
        @(negedge clock);
        acc = reset && in_valid && in_ready;
        if (acc) exp_q.push_back(model(in_mant, in_pos, in_nz, in_exp));
        if (reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else check("beat", {out_mant, out_exp, out_zero, out_sub}, exp_q.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [XLEN-1:0] m, input logic [XLOG-1:0] pos,
                        input logic nz, input logic [ELEN-1:0] e);
        bit done;
        done = 0;
        in_mant = m; in_pos = pos; in_nz = nz; in_exp = e; in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = acc;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [XLEN-1:0] bm[4];
    logic [XLOG-1:0] bp[4];
    logic [ELEN-1:0] be[4];
    logic [255:0]    snap;
    int              bi;
    int              out_base;
    int              p;

    initial begin
        // Reset state
        repeat (3) cycle();
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {out_mant, out_exp, out_zero, out_sub}, 0);
        check("reset_in_ready", in_ready, 1);
        reset = 1'b1;

        // Walking one: one beat per cycle, every result normalized to bit 127
        out_ready = 1'b1;
        out_base  = n_out;
        for (int k = 0; k < XLEN; k++) begin
            in_valid = 1'b1;
            in_mant  = ONE << k;
            in_pos   = XLOG'(k);
            in_nz    = 1'b1;
            in_exp   = 12'd200;
            cycle();
            check("walk_accept", acc, 1);
        end
        in_valid = 1'b0;
        repeat (DEPTH) cycle();
        check("walk_count", n_out - out_base, XLEN);
        check("walk_empty", exp_q.size(), 0);

        // Clamp, exact boundary, and zero
        send(ONE, 7'd0, 1'b1, 12'd5);
        send(ONE << 120, 7'd120, 1'b1, 12'd7);
        send('0, 7'h55, 1'b0, 12'd300);
        send(ONE << 127, 7'd127, 1'b1, 12'd0);
        drain();

        // Backpressure: four beats against a stalled output
        for (int i = 0; i < 4; i++) begin
            bp[i] = XLOG'(100 + i * 5);
            bm[i] = (ONE << bp[i]) | XLEN'(i + 1);
            be[i] = ELEN'(300 + i);
        end
        out_ready = 1'b0;
        bi = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (bi < 4);
            if (bi < 4) begin
                in_mant = bm[bi]; in_pos = bp[bi]; in_nz = 1'b1; in_exp = be[bi];
            end
            cycle();
            if (acc) bi++;
        end
        check("stall_accepted", bi, DEPTH);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        snap = {out_valid, out_mant, out_exp, out_zero, out_sub};
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("stall_hold", {out_valid, out_mant, out_exp, out_zero, out_sub}, snap);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && bi < 4; c++) begin
            in_valid = 1'b1;
            in_mant = bm[bi]; in_pos = bp[bi]; in_nz = 1'b1; in_exp = be[bi];
            cycle();
            if (acc) bi++;
        end
        check("stall_all_sent", bi, 4);
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_mant = bm[i]; in_pos = bp[i]; in_nz = 1'b1; in_exp = be[i];
            cycle();
        end
        reset = 1'b0;
        cycle();
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_outputs", {out_mant, out_exp, out_zero, out_sub}, 0);
        check("rst_mid_in_ready", in_ready, 1);
        exp_q.delete();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rst_no_stale", out_valid, 0);
        end

        // Randomized traffic with random handshakes
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                in_mant = '0;
                in_nz   = 1'b0;
                in_pos  = XLOG'($urandom_range(0, XLEN - 1));
            end else begin
                p       = $urandom_range(0, XLEN - 1);
                in_mant = (ONE << p) | ({$urandom, $urandom, $urandom, $urandom} & ((ONE << p) - ONE));
                in_pos  = XLOG'(p);
                in_nz   = 1'b1;
            end
            in_exp = ($urandom_range(0, 2) == 0) ? ELEN'($urandom_range(0, 140))
                                                 : ELEN'($urandom_range(0, 4095));
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
